// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx : start + LSB-first data + optional parity + stop framer    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    par_en_q;
   logic                    par_typ_q;
   logic [CW-1:0]           cnt_q;
   logic                    tx_q;
   logic                    busy_q;

   logic [CW-1:0]           cnt_d;
   logic                    parity_d;

   assign cnt_d    = cnt_q + CW'(1);
   assign parity_d = par_typ_q ? ~^data_q : ^data_q;

   // Each state loads the line value of the bit that follows it, so the
   // outputs come straight from flops and change exactly on the bit edge.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         cnt_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (Data_Valid) begin
                  data_q    <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= START;
               end
            end
            START: begin
               cnt_q   <= '0;
               tx_q    <= data_q[0];
               state_q <= DATA;
            end
            DATA: begin
               if (cnt_q == C_LAST_BIT) begin
                  if (par_en_q) begin
                     tx_q    <= parity_d;
                     state_q <= PARITY;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_d;
                  tx_q  <= data_q[cnt_d];
               end
            end
            PARITY: begin
               tx_q    <= 1'b1;
               state_q <= STOP;
            end
            STOP: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one parallel byte into a standard asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It sits directly upstream of the UART receiver and drives the receiver's serial input at one bit per `CLK` cycle; `CLK` is the baud-rate clock (115.2 kHz nominal, 8680.55 ns period). Parity polarity and framing match the receiver exactly, so a `uart_tx` to receiver loopback is error-free.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `CLK`  in  1  baud-rate clock; all logic on the rising edge.
- `RST`  in  1  synchronous active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
- `Data_Valid`  in  1  request to send `P_DATA`; accepted only when `Busy`=0.
- `PAR_EN`  in  1  1 = insert parity bit; sampled on acceptance.
- `PAR_TYP`  in  1  0 = even, 1 = odd; sampled on acceptance.
- `TX_OUT`  out  1  serial line; idles high.
- `Busy`  out  1  high from the acceptance edge through the end of the stop bit.

## Operation
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- `IDLE`: `TX_OUT`=1, `Busy`=0. On an edge with `Data_Valid`=1, latch `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers and go to `START`.
- `START`: `TX_OUT`=0 for one cycle, then `DATA` with bit counter = 0.
- `DATA`: `TX_OUT` = latched data[counter], LSB first. Counter increments each cycle. After bit DATA_WIDTH-1, go to `PARITY` if latched `PAR_EN`=1, otherwise to `STOP`.
- `PARITY`: for one cycle, `TX_OUT` = ^data when even, ~^data when odd. Parity is computed from the latched byte, not the live `P_DATA`.
- `STOP`: `TX_OUT`=1 for one cycle, then `IDLE`.
- Bit counter is $clog2(DATA_WIDTH) bits wide. It resets to 0 on every entry to `DATA`; there is no wrap behaviour.
- `Data_Valid` while `Busy`=1 is ignored. There is no queuing and the request is not remembered.
- `P_DATA`, `PAR_EN` and `PAR_TYP` changes after acceptance have no effect on the frame in flight.
- `TX_OUT` and `Busy` are driven directly from flops. No combinational path from any input to any output, so the line is glitch-free.

## Timing
- Reset: on any rising edge with `RST`=0, the block goes to `IDLE`, `TX_OUT`=1, `Busy`=0, and counter and latched registers clear to 0.
- Reset mid-frame aborts the frame immediately. The line returns high at that same edge and no partial bits follow.
- `Data_Valid`=1 together with `RST`=0 on the same edge: reset wins and the request is dropped.
- Acceptance at edge k: after edge k, `TX_OUT`=0 and `Busy`=1. The start bit spans k..k+1.
- Data bit i spans edge k+1+i to k+2+i.
- Parity is enabled:
  - Parity bit spans k+9..k+10.
  - Stop bit spans k+10..k+11.
  - `Busy` falls at edge k+11.
- Parity is disabled:
  - Stop bit spans k+9..k+10.
  - `Busy` falls at edge k+10.
- Frame length is 10 cycles without parity and 11 with parity.
- Earliest next acceptance is the edge at which `Busy` is first observed 0. That gives a minimum of one idle-high cycle between back-to-back frames.
- `Data_Valid` held high continuously sends the same byte repeatedly. Each frame is separated by exactly one idle cycle.

## Test plan
- Reset:
  - Stimulus: hold `RST`=0 for 2 cycles with `Data_Valid`=1.
  - Required response: `TX_OUT`=1 and `Busy`=0 throughout; no frame after release with `Data_Valid`=0.
- 0xB2, no parity:
  - Stimulus: `PAR_EN`=0.
  - Required response: `TX_OUT` per cycle = 0, 0,1,0,0,1,1,0,1, 1, then idle 1.
  - `Busy` is high for exactly 10 cycles.
- 0xB2, even then odd parity:
  - Required response: parity bit = 0 (even) and 1 (odd), in the cycle after data bit 7.
  - `Busy` is high for 11 cycles.
- Back-to-back 0xB2 then 0xA4, even parity:
  - Stimulus: second `Data_Valid` held high from mid-frame.
  - Required response: the second request is ignored until `Busy`=0.
  - Second frame is 0, 0,0,1,0,0,1,0,1, parity 1, stop 1, after exactly one idle cycle.
- Config change mid-frame:
  - Stimulus: toggle `PAR_EN`, `PAR_TYP` and `P_DATA` during data bits of a 0xB2 even-parity frame.
  - Required response: the transmitted frame is unchanged.
- Reset mid-frame:
  - Stimulus: assert `RST`=0 during data bit 4.
  - Required response: after that edge `TX_OUT`=1 and `Busy`=0; a subsequent `Data_Valid` with 0x55 produces a clean full frame.
